uart_cmd_assembler: RTL and testbench
=====================================

Name: uart_cmd_assembler

Overview:
- Sits inside the Knight, between the UART transceiver and the command processor.
- Receive path: packs two received bytes, high byte first, into one 16-bit move or calibrate command (e.g. 0x4BF1, 0x57F2) and holds it for the command processor.
- Transmit path: accepts a response byte from the command processor (e.g. ack 0xA5) and hands it to the transmitter.
- An inter-byte timeout discards a lone high byte so a dropped byte cannot leave the receive path out of step.

Parameters:
TIMEOUT_CLKS, 1000000, clocks allowed between high and low byte before the high byte is discarded
TO_W, 20, width of timeout counter; must satisfy 2^TO_W > TIMEOUT_CLKS

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
rx_rdy  input  1  UART has a received byte
rx_data  input  8  received byte
clr_rx_rdy  output  1  byte consumed; UART drops rx_rdy next edge
cmd  output  16  assembled command {high, low}
cmd_rdy  output  1  cmd valid; held until cleared
clr_cmd_rdy  input  1  command processor consumed cmd
resp  input  8  response byte to send
snd_resp  input  1  request to send resp
tx_data  output  8  byte to UART transmitter
trmt  output  1  one-cycle start pulse to transmitter
tx_done  input  1  transmitter finished byte
resp_sent  output  1  one-cycle pulse: response completed
byte_to  output  1  one-cycle pulse: high byte discarded on timeout
resp_drop  output  1  one-cycle pulse: snd_resp ignored because transmitter busy

Behaviour:
- Reset (async, any cycle, including mid-assembly or mid-transmit) forces both FSMs to idle. Output reset values:
  - cmd=0, cmd_rdy=0, tx_data=0.
  - trmt, resp_sent, byte_to, resp_drop = 0.
  - Held high byte and timeout counter cleared.
- Receive FSM states: RX_HI, RX_LO.
  - RX_HI, rx_rdy=1:
    - Assert clr_rx_rdy combinationally in the same cycle.
    - Capture rx_data into the high register at the edge.
    - Clear cmd_rdy at the same edge; a new command is starting.
    - Clear the counter and go to RX_LO.
  - RX_LO, rx_rdy=1:
    - Assert clr_rx_rdy combinationally.
    - At the edge, cmd <= {hi, rx_data} and cmd_rdy <= 1, registered.
    - cmd_rdy is visible 1 cycle after the low byte is accepted. Return to RX_HI.
  - RX_LO, rx_rdy=0: increment the counter each cycle.
    - When the counter == TIMEOUT_CLKS-1: pulse byte_to for one cycle, discard the high byte, go to RX_HI.
    - cmd and cmd_rdy are unchanged by a timeout.
    - A byte arriving in the same cycle the counter hits the limit is accepted as the low byte; no timeout.
- clr_cmd_rdy clears cmd_rdy at the next edge.
  - If clr_cmd_rdy and low-byte completion coincide, set wins: cmd_rdy=1 with the new cmd.
- clr_rx_rdy is never asserted when rx_rdy=0.
- cmd changes only on low-byte completion; it is stable while cmd_rdy=1.
- Transmit FSM states: TX_IDLE, TX_BUSY. It is independent of the receive FSM.
  - TX_IDLE, snd_resp=1:
    - At the edge, tx_data <= resp and trmt <= 1 for exactly one cycle.
    - Go to TX_BUSY.
  - TX_BUSY, tx_done=1: resp_sent pulses one cycle, registered, then return to TX_IDLE.
  - tx_data is held through TX_BUSY.
  - snd_resp in TX_BUSY is not queued; resp_drop pulses one cycle.
  - tx_done in TX_IDLE is ignored.
- Receive and transmit may be active simultaneously. Both pulse outputs may assert in the same cycle.

Test Plan:
1. rx bytes 0x4B then 0xF1, 200 clks apart -> clr_rx_rdy one cycle per byte; cmd=0x4BF1 and cmd_rdy=1 one cycle after the second byte. cmd_rdy holds until clr_cmd_rdy, clearing at the next edge.
2. With TIMEOUT_CLKS=1000: rx 0x57 then nothing -> byte_to pulses exactly 1000 clks after the capture edge. Then rx 0x57, 0xF2 -> cmd=0x57F2; no stale high byte used.
3. cmd_rdy=1 holding 0x4BF1; rx 0x57 -> cmd_rdy drops at that capture edge. Drive clr_cmd_rdy in the same cycle as low byte 0xF2 -> cmd_rdy=1, cmd=0x57F2.
4. snd_resp with resp=0xA5 -> tx_data=0xA5 and trmt high one cycle. Second snd_resp (resp=0x5A) while busy -> resp_drop pulse, tx_data stays 0xA5. tx_done -> resp_sent one cycle.
5. Assert rst after high byte 0x4B and during TX_BUSY -> all outputs 0 immediately (asynchronous). Then 0x12, 0x34 -> cmd=0x1234, proving the high byte was discarded.
6. Low byte arriving on the exact timeout-limit cycle -> accepted; cmd formed, no byte_to.

Source files
------------

// File: rtl/uart_cmd_assembler.sv
// Packs received UART byte pairs into 16-bit commands and forwards response bytes
// to the transmitter; a lone high byte is dropped after an inter-byte timeout.
module uart_cmd_assembler #(
    parameter int TIMEOUT_CLKS = 1000000,
    parameter int TO_W         = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_rdy,
    input  logic [7:0]  rx_data,
    output logic        clr_rx_rdy,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp,
    input  logic        snd_resp,
    output logic [7:0]  tx_data,
    output logic        trmt,
    input  logic        tx_done,
    output logic        resp_sent,
    output logic        byte_to,
    output logic        resp_drop
);

    typedef enum logic {RX_HI, RX_LO} rx_state_t;
    typedef enum logic {TX_IDLE, TX_BUSY} tx_state_t;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CLKS - 1);

    rx_state_t       rx_state_q, rx_state_d;
    tx_state_t       tx_state_q, tx_state_d;
    logic [7:0]      hi_q, hi_d;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic [15:0]     cmd_q, cmd_d;
    logic            cmd_rdy_q, cmd_rdy_d;
    logic            byte_to_q, byte_to_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            trmt_q, trmt_d;
    logic            resp_sent_q, resp_sent_d;
    logic            resp_drop_q, resp_drop_d;

    always_comb begin
        rx_state_d = rx_state_q;
        hi_d       = hi_q;
        cnt_d      = cnt_q;
        cmd_d      = cmd_q;
        cmd_rdy_d  = cmd_rdy_q;
        byte_to_d  = 1'b0;
        clr_rx_rdy = 1'b0;
        if (clr_cmd_rdy)
            cmd_rdy_d = 1'b0;
        case (rx_state_q)
            RX_HI: begin
                if (rx_rdy) begin
                    clr_rx_rdy = 1'b1;
                    hi_d       = rx_data;
                    cmd_rdy_d  = 1'b0;
                    cnt_d      = '0;
                    rx_state_d = RX_LO;
                end
            end
            RX_LO: begin
                // A low byte on the limit cycle takes priority over the timeout.
                if (rx_rdy) begin
                    clr_rx_rdy = 1'b1;
                    cmd_d      = {hi_q, rx_data};
                    cmd_rdy_d  = 1'b1;
                    rx_state_d = RX_HI;
                end else if (cnt_q == TO_LAST) begin
                    byte_to_d  = 1'b1;
                    hi_d       = '0;
                    cnt_d      = '0;
                    rx_state_d = RX_HI;
                end else begin
                    cnt_d = cnt_q + TO_W'(1);
                end
            end
            default: rx_state_d = RX_HI;
        endcase
    end

    always_comb begin
        tx_state_d  = tx_state_q;
        tx_data_d   = tx_data_q;
        trmt_d      = 1'b0;
        resp_sent_d = 1'b0;
        resp_drop_d = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                if (snd_resp) begin
                    tx_data_d  = resp;
                    trmt_d     = 1'b1;
                    tx_state_d = TX_BUSY;
                end
            end
            TX_BUSY: begin
                if (snd_resp)
                    resp_drop_d = 1'b1;
                if (tx_done) begin
                    resp_sent_d = 1'b1;
                    tx_state_d  = TX_IDLE;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state_q  <= RX_HI;
            tx_state_q  <= TX_IDLE;
            hi_q        <= '0;
            cnt_q       <= '0;
            cmd_q       <= '0;
            cmd_rdy_q   <= 1'b0;
            byte_to_q   <= 1'b0;
            tx_data_q   <= '0;
            trmt_q      <= 1'b0;
            resp_sent_q <= 1'b0;
            resp_drop_q <= 1'b0;
        end else begin
            rx_state_q  <= rx_state_d;
            tx_state_q  <= tx_state_d;
            hi_q        <= hi_d;
            cnt_q       <= cnt_d;
            cmd_q       <= cmd_d;
            cmd_rdy_q   <= cmd_rdy_d;
            byte_to_q   <= byte_to_d;
            tx_data_q   <= tx_data_d;
            trmt_q      <= trmt_d;
            resp_sent_q <= resp_sent_d;
            resp_drop_q <= resp_drop_d;
        end
    end

    assign cmd       = cmd_q;
    assign cmd_rdy   = cmd_rdy_q;
    assign byte_to   = byte_to_q;
    assign tx_data   = tx_data_q;
    assign trmt      = trmt_q;
    assign resp_sent = resp_sent_q;
    assign resp_drop = resp_drop_q;

endmodule

// File: tb/tb_uart_cmd_assembler.sv
// Bench for uart_cmd_assembler: directed scenarios plus a randomized run
// compared cycle by cycle against a behavioural model of the byte protocol.
module tb_uart_cmd_assembler;

    localparam int TO = 1000;

    logic        clk;
    logic        rst;
    logic        rx_rdy;
    logic [7:0]  rx_data;
    logic        clr_rx_rdy;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic [7:0]  resp;
    logic        snd_resp;
    logic [7:0]  tx_data;
    logic        trmt;
    logic        tx_done;
    logic        resp_sent;
    logic        byte_to;
    logic        resp_drop;

    int n_cmp;
    int n_fail;

    // behavioural model state
    bit        m_pend;
    bit [7:0]  m_hi;
    int        m_age;
    bit [15:0] m_cmd;
    bit        m_rdy;
    bit        m_bto;
    bit        m_busy;
    bit [7:0]  m_txdata;
    bit        m_trmt;
    bit        m_sent;
    bit        m_drop;

    uart_cmd_assembler #(.TIMEOUT_CLKS(TO), .TO_W(10)) dut (
        .clk(clk), .rst(rst),
        .rx_rdy(rx_rdy), .rx_data(rx_data), .clr_rx_rdy(clr_rx_rdy),
        .cmd(cmd), .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy),
        .resp(resp), .snd_resp(snd_resp), .tx_data(tx_data), .trmt(trmt),
        .tx_done(tx_done), .resp_sent(resp_sent), .byte_to(byte_to), .resp_drop(resp_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_pend = 0; m_hi = 0; m_age = 0; m_cmd = 0; m_rdy = 0; m_bto = 0;
        m_busy = 0; m_txdata = 0; m_trmt = 0; m_sent = 0; m_drop = 0;
    endtask

    // One clock edge of the protocol: a received byte is either the first of a
    // pair or completes it; a pending first byte expires after TO idle edges.
    task automatic model_edge();
        bit completed;
        completed = 0;
        m_bto = 0; m_trmt = 0; m_sent = 0; m_drop = 0;
        if (rx_rdy) begin
            if (!m_pend) begin
                m_pend = 1; m_hi = rx_data; m_age = 0; m_rdy = 0;
            end else begin
                m_cmd = {m_hi, rx_data}; m_rdy = 1; m_pend = 0; completed = 1;
            end
        end else if (m_pend) begin
            m_age++;
            if (m_age == TO) begin
                m_pend = 0; m_bto = 1;
            end
        end
        if (clr_cmd_rdy && !completed) m_rdy = 0;
        if (!m_busy) begin
            if (snd_resp) begin
                m_txdata = resp; m_trmt = 1; m_busy = 1;
            end
        end else begin
            if (snd_resp) m_drop = 1;
            if (tx_done) begin
                m_sent = 1; m_busy = 0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else model_edge();
        #1;
    endtask

    task automatic test_reset();
        rst = 1; rx_rdy = 0; rx_data = 0; clr_cmd_rdy = 0; resp = 0; snd_resp = 0; tx_done = 0;
        model_reset();
        tick(); tick();
        n_cmp++; if (cmd !== 16'h0) begin n_fail++; $display("FAIL reset_cmd: got %h want 0000", cmd); end
        n_cmp++; if (cmd_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_rdy: got %b want 0", cmd_rdy); end
        n_cmp++; if (tx_data !== 8'h0) begin n_fail++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
        n_cmp++; if ({trmt, resp_sent, byte_to, resp_drop} !== 4'b0) begin
            n_fail++; $display("FAIL reset_pulses: got %b want 0000", {trmt, resp_sent, byte_to, resp_drop});
        end
        n_cmp++; if (clr_rx_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_clr_rx_rdy: got %b want 0", clr_rx_rdy); end
        rst = 0;
        tick();
    endtask

    task automatic test_basic_cmd();
        rx_rdy = 1; rx_data = 8'h4B; #1;
        n_cmp++; if (clr_rx_rdy !== 1'b1) begin n_fail++; $display("FAIL basic_clr_hi: got %b want 1", clr_rx_rdy); end
        tick();
        rx_rdy = 0; #1;
        n_cmp++; if (clr_rx_rdy !== 1'b0) begin n_fail++; $display("FAIL basic_clr_idle: got %b want 0", clr_rx_rdy); end
        n_cmp++; if (cmd_rdy !== 1'b0) begin n_fail++; $display("FAIL basic_rdy_early: got %b want 0", cmd_rdy); end
        repeat (199) tick();
        rx_rdy = 1; rx_data = 8'hF1; #1;
        n_cmp++; if (clr_rx_rdy !== 1'b1) begin n_fail++; $display("FAIL basic_clr_lo: got %b want 1", clr_rx_rdy); end
        tick();
        rx_rdy = 0;
        n_cmp++; if (cmd !== 16'h4BF1) begin n_fail++; $display("FAIL basic_cmd: got %h want 4bf1", cmd); end
        n_cmp++; if (cmd_rdy !== 1'b1) begin n_fail++; $display("FAIL basic_rdy: got %b want 1", cmd_rdy); end
        repeat (5) tick();
        n_cmp++; if (cmd_rdy !== 1'b1) begin n_fail++; $display("FAIL basic_rdy_hold: got %b want 1", cmd_rdy); end
        clr_cmd_rdy = 1;
        tick();
        clr_cmd_rdy = 0;
        n_cmp++; if (cmd_rdy !== 1'b0) begin n_fail++; $display("FAIL basic_rdy_clr: got %b want 0", cmd_rdy); end
        n_cmp++; if (cmd !== 16'h4BF1) begin n_fail++; $display("FAIL basic_cmd_stable: got %h want 4bf1", cmd); end
    endtask

    task automatic test_timeout();
        int first_k;
        int pulses;
        first_k = -1; pulses = 0;
        rx_rdy = 1; rx_data = 8'h57;
        tick();
        rx_rdy = 0;
        for (int k = 1; k <= TO; k++) begin
            tick();
            if (byte_to === 1'b1) begin
                pulses++;
                if (first_k < 0) first_k = k;
            end
        end
        n_cmp++; if (first_k != TO) begin n_fail++; $display("FAIL timeout_when: got %0d want %0d", first_k, TO); end
        n_cmp++; if (pulses != 1) begin n_fail++; $display("FAIL timeout_count: got %0d want 1", pulses); end
        tick();
        n_cmp++; if (byte_to !== 1'b0) begin n_fail++; $display("FAIL timeout_one_cycle: got %b want 0", byte_to); end
        n_cmp++; if (cmd !== 16'h4BF1 || cmd_rdy !== 1'b0) begin
            n_fail++; $display("FAIL timeout_cmd_kept: got %h/%b want 4bf1/0", cmd, cmd_rdy);
        end
        rx_rdy = 1; rx_data = 8'h57;
        tick();
        rx_rdy = 0;
        n_cmp++; if (cmd_rdy !== 1'b0) begin n_fail++; $display("FAIL timeout_stale_hi: got %b want 0", cmd_rdy); end
        tick();
        rx_rdy = 1; rx_data = 8'hF2;
        tick();
        rx_rdy = 0;
        n_cmp++; if (cmd !== 16'h57F2 || cmd_rdy !== 1'b1) begin
            n_fail++; $display("FAIL timeout_recover: got %h/%b want 57f2/1", cmd, cmd_rdy);
        end
    endtask

    task automatic test_overlap();
        rx_rdy = 1; rx_data = 8'h4B;
        tick();
        rx_data = 8'hF1;
        tick();
        rx_rdy = 0;
        n_cmp++; if (cmd !== 16'h4BF1 || cmd_rdy !== 1'b1) begin
            n_fail++; $display("FAIL overlap_b2b: got %h/%b want 4bf1/1", cmd, cmd_rdy);
        end
        tick();
        rx_rdy = 1; rx_data = 8'h57;
        tick();
        rx_rdy = 0;
        n_cmp++; if (cmd_rdy !== 1'b0) begin n_fail++; $display("FAIL overlap_hi_clears: got %b want 0", cmd_rdy); end
        n_cmp++; if (cmd !== 16'h4BF1) begin n_fail++; $display("FAIL overlap_cmd_hold: got %h want 4bf1", cmd); end
        tick();
        rx_rdy = 1; rx_data = 8'hF2; clr_cmd_rdy = 1;
        tick();
        rx_rdy = 0; clr_cmd_rdy = 0;
        n_cmp++; if (cmd !== 16'h57F2 || cmd_rdy !== 1'b1) begin
            n_fail++; $display("FAIL overlap_set_wins: got %h/%b want 57f2/1", cmd, cmd_rdy);
        end
    endtask

    task automatic test_tx();
        snd_resp = 1; resp = 8'hA5;
        tick();
        snd_resp = 0;
        n_cmp++; if (trmt !== 1'b1 || tx_data !== 8'hA5) begin
            n_fail++; $display("FAIL tx_start: got trmt=%b data=%h want 1/a5", trmt, tx_data);
        end
        tick();
        n_cmp++; if (trmt !== 1'b0) begin n_fail++; $display("FAIL tx_trmt_pulse: got %b want 0", trmt); end
        snd_resp = 1; resp = 8'h5A;
        tick();
        snd_resp = 0;
        n_cmp++; if (resp_drop !== 1'b1 || tx_data !== 8'hA5 || trmt !== 1'b0) begin
            n_fail++; $display("FAIL tx_drop: got drop=%b data=%h trmt=%b want 1/a5/0", resp_drop, tx_data, trmt);
        end
        tick();
        n_cmp++; if (resp_drop !== 1'b0) begin n_fail++; $display("FAIL tx_drop_pulse: got %b want 0", resp_drop); end
        tx_done = 1;
        tick();
        tx_done = 0;
        n_cmp++; if (resp_sent !== 1'b1) begin n_fail++; $display("FAIL tx_sent: got %b want 1", resp_sent); end
        tick();
        n_cmp++; if (resp_sent !== 1'b0) begin n_fail++; $display("FAIL tx_sent_pulse: got %b want 0", resp_sent); end
        tx_done = 1;
        tick();
        tx_done = 0;
        n_cmp++; if (resp_sent !== 1'b0) begin n_fail++; $display("FAIL tx_done_idle: got %b want 0", resp_sent); end
        snd_resp = 1; resp = 8'h3C;
        tick();
        snd_resp = 0; tx_done = 1;
        n_cmp++; if (trmt !== 1'b1 || tx_data !== 8'h3C) begin
            n_fail++; $display("FAIL tx_restart: got trmt=%b data=%h want 1/3c", trmt, tx_data);
        end
        tick();
        tx_done = 0;
        n_cmp++; if (resp_sent !== 1'b1) begin n_fail++; $display("FAIL tx_sent2: got %b want 1", resp_sent); end
    endtask

    task automatic test_async_reset();
        rx_rdy = 1; rx_data = 8'h4B; snd_resp = 1; resp = 8'h77;
        tick();
        rx_rdy = 0; snd_resp = 0;
        #2;
        rst = 1;
        #1;
        model_reset();
        n_cmp++; if (cmd !== 16'h0 || cmd_rdy !== 1'b0) begin
            n_fail++; $display("FAIL arst_cmd: got %h/%b want 0000/0", cmd, cmd_rdy);
        end
        n_cmp++; if (tx_data !== 8'h0 || trmt !== 1'b0) begin
            n_fail++; $display("FAIL arst_tx: got %h/%b want 00/0", tx_data, trmt);
        end
        tick();
        rst = 0;
        rx_rdy = 1; rx_data = 8'h12; snd_resp = 1; resp = 8'hC3;
        tick();
        rx_data = 8'h34; snd_resp = 0;
        n_cmp++; if (trmt !== 1'b1 || resp_drop !== 1'b0) begin
            n_fail++; $display("FAIL arst_tx_idle: got trmt=%b drop=%b want 1/0", trmt, resp_drop);
        end
        tick();
        rx_rdy = 0; tx_done = 1;
        n_cmp++; if (cmd !== 16'h1234 || cmd_rdy !== 1'b1) begin
            n_fail++; $display("FAIL arst_rx_fresh: got %h/%b want 1234/1", cmd, cmd_rdy);
        end
        tick();
        tx_done = 0;
    endtask

    task automatic test_limit_edge();
        int pulses;
        pulses = 0;
        rx_rdy = 1; rx_data = 8'h9C;
        tick();
        rx_rdy = 0;
        repeat (TO - 1) begin
            tick();
            if (byte_to === 1'b1) pulses++;
        end
        rx_rdy = 1; rx_data = 8'hD3;
        tick();
        rx_rdy = 0;
        if (byte_to === 1'b1) pulses++;
        n_cmp++; if (pulses != 0) begin n_fail++; $display("FAIL limit_no_timeout: got %0d pulses want 0", pulses); end
        n_cmp++; if (cmd !== 16'h9CD3 || cmd_rdy !== 1'b1) begin
            n_fail++; $display("FAIL limit_accept: got %h/%b want 9cd3/1", cmd, cmd_rdy);
        end
        tick();
        n_cmp++; if (byte_to !== 1'b0) begin n_fail++; $display("FAIL limit_late_timeout: got %b want 0", byte_to); end
    endtask

    task automatic test_random();
        logic [28:0] got;
        bit   [28:0] exp;
        int          pct;
        rst = 1;
        tick();
        rst = 0;
        for (int i = 0; i < 9000; i++) begin
            pct = (i < 3000) ? 100 : 1;
            rx_rdy      = ($urandom_range(0, 999) < pct);
            rx_data     = 8'($urandom);
            clr_cmd_rdy = ($urandom_range(0, 99) < 5);
            snd_resp    = ($urandom_range(0, 99) < 10);
            resp        = 8'($urandom);
            tx_done     = ($urandom_range(0, 99) < 10);
            #1;
            n_cmp++; if (clr_rx_rdy !== rx_rdy) begin
                n_fail++; $display("FAIL rand_clr_rx_rdy[%0d]: got %b want %b", i, clr_rx_rdy, rx_rdy);
            end
            tick();
            got = {cmd, cmd_rdy, tx_data, trmt, resp_sent, byte_to, resp_drop};
            exp = {m_cmd, m_rdy, m_txdata, m_trmt, m_sent, m_bto, m_drop};
            n_cmp++; if (got !== exp) begin
                n_fail++;
                $display("FAIL rand_outputs[%0d]: got cmd=%h rdy=%b tx=%h pulses=%b want cmd=%h rdy=%b tx=%h pulses=%b",
                         i, got[28:13], got[12], got[11:4], got[3:0], exp[28:13], exp[12], exp[11:4], exp[3:0]);
            end
        end
        rx_rdy = 0; clr_cmd_rdy = 0; snd_resp = 0; tx_done = 0;
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        test_reset();
        test_basic_cmd();
        test_timeout();
        test_overlap();
        test_tx();
        test_async_reset();
        test_limit_edge();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
